// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and sizing helpers for the scan chain controller.
// Holds the FSM state encoding and the functions that size the phase
// counter and give the start-to-done latency of one test.
package scan_chain_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    // The counter is sized for a shift phase ($clog2(CHAIN_LEN+1)). It is
    // widened only when the capture phase is longer than a shift phase,
    // e.g. a 2-flop chain with 15 capture clocks.
    function automatic int cnt_width(input int chain_len, input int cap_cycles);
        int w_shift;
        int w_cap;
        w_shift = $clog2(chain_len + 1);
        w_cap   = $clog2(cap_cycles + 1);
        return (w_shift > w_cap) ? w_shift : w_cap;
    endfunction

    // Cycles from the edge that samples start to the done cycle.
    function automatic int test_latency(input int chain_len, input int cap_cycles);
        return 2 * chain_len + cap_cycles + 1;
    endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Control/chain bundle between a tester and scan_chain_ctrl.
//   start, pat_in : test request and pattern (bit i targets chain flop i)
//   so            : Q of the last chain flop
//   se, si        : scan enable and scan-in of the first flop
//   busy, done    : status; done is a one-cycle completion pulse
//   resp_out      : captured response (bit i = flop i after capture)
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 16
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pat_in;
    logic                 so;
    logic                 se;
    logic                 si;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] resp_out;

    modport master (
        output start, pat_in, so,
        input  se, si, busy, done, resp_out
    );

    modport slave (
        input  start, pat_in, so,
        output se, si, busy, done, resp_out
    );
endinterface

// File: rtl/scan_chain_ctrl_shreg.sv
// N-bit parallel-load / serial-shift register, shifting toward the MSB.
//   clk, rst_n : clock and asynchronous active-low reset (clears q)
//   load       : parallel load of load_val (wins over shift)
//   shift      : q <= {q[N-2:0], sin}
//   q          : register contents
module scan_chain_ctrl_shreg #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         shift,
    input  logic         sin,
    output logic [N-1:0] q
);

    logic [N-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= load_val;
        end else if (shift) begin
            q_reg <= {q_reg[N-2:0], sin};
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain test controller: shifts a pattern into an external scan chain,
// pulses CAP_CYCLES functional clocks, then shifts the response back out.
//   CLK : rising-edge clock shared with the chain
//   RN  : asynchronous active-low reset (aborts any test in flight)
//   bus : start/pat_in/so in, se/si/busy/done/resp_out out (all registered)
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN  = 16,
    parameter int CAP_CYCLES = 1
) (
    input  logic               CLK,
    input  logic               RN,
    scan_chain_ctrl_if.slave   bus
);

    localparam int CW = cnt_width(CHAIN_LEN, CAP_CYCLES);
    // The counter is loaded with (phase length - 1) and the phase ends at 0.
    localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(CAP_CYCLES - 1);

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 se_reg, busy_reg, done_reg;
    logic                 ser_load;
    logic                 ser_shift;
    logic                 des_shift;
    logic [CHAIN_LEN-1:0] ser_q;
    logic [CHAIN_LEN-1:0] des_q;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ser_load   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_LOAD;
                    cnt_next   = SHIFT_LAST;
                    ser_load   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (cnt_reg == '0) begin
                    state_next = ST_CAPTURE;
                    cnt_next   = CAP_LAST;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_CAPTURE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_UNLOAD;
                    cnt_next   = SHIFT_LAST;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_UNLOAD: begin
                if (cnt_reg == '0) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state, which also gives the LOAD->CAPTURE se drop with no
    // gap cycle.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            se_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            se_reg    <= (state_next == ST_LOAD) || (state_next == ST_UNLOAD);
            busy_reg  <= (state_next == ST_LOAD) || (state_next == ST_CAPTURE) ||
                         (state_next == ST_UNLOAD);
            done_reg  <= (state_next == ST_DONE);
        end
    end

    // Serializer: its MSB is si. It shifts zeros in on every LOAD edge, so
    // after the last shift it is empty and si stays 0 through CAPTURE/UNLOAD.
    assign ser_shift = (state_reg == ST_LOAD);
    assign des_shift = (state_reg == ST_UNLOAD);

    scan_chain_ctrl_shreg #(.N(CHAIN_LEN)) u_ser (
        .clk      (CLK),
        .rst_n    (RN),
        .load     (ser_load),
        .load_val (bus.pat_in),
        .shift    (ser_shift),
        .sin      (1'b0),
        .q        (ser_q)
    );

    // Deserializer: so carries flop CHAIN_LEN-1 first, so after CHAIN_LEN
    // shifts toward the MSB bit i holds flop i.
    scan_chain_ctrl_shreg #(.N(CHAIN_LEN)) u_des (
        .clk      (CLK),
        .rst_n    (RN),
        .load     (1'b0),
        .load_val ('0),
        .shift    (des_shift),
        .sin      (bus.so),
        .q        (des_q)
    );

    assign bus.se       = se_reg;
    assign bus.si       = ser_q[CHAIN_LEN-1];
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.resp_out = des_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (8-flop/1 capture, 2-flop/3
// captures), each driving a behavioural scan-DFF chain whose functional D is
// either Q or ~Q. Expected responses come from the chain rule alone.
module tb_scan_chain_ctrl;

    localparam int NA = 8;
    localparam int CA = 1;
    localparam int NB = 2;
    localparam int CB = 3;

    logic clk = 1'b0;
    logic rn  = 1'b1;
    always #5 clk = ~clk;

    scan_chain_ctrl_if #(.CHAIN_LEN(NA)) a_if ();
    scan_chain_ctrl_if #(.CHAIN_LEN(NB)) b_if ();

    scan_chain_ctrl #(.CHAIN_LEN(NA), .CAP_CYCLES(CA)) dut_a (
        .CLK (clk),
        .RN  (rn),
        .bus (a_if.slave)
    );

    scan_chain_ctrl #(.CHAIN_LEN(NB), .CAP_CYCLES(CB)) dut_b (
        .CLK (clk),
        .RN  (rn),
        .bus (b_if.slave)
    );

    // Scan chains: si feeds flop 0, flop i feeds flop i+1, so = last flop.
    logic [NA-1:0] chain_a = '0;
    logic [NB-1:0] chain_b = '0;
    logic          inv_a   = 1'b0;
    logic          inv_b   = 1'b0;

    always @(posedge clk) begin
        if (a_if.se) chain_a <= {chain_a[NA-2:0], a_if.si};
        else         chain_a <= inv_a ? ~chain_a : chain_a;
        if (b_if.se) chain_b <= {chain_b[NB-2:0], b_if.si};
        else         chain_b <= inv_b ? ~chain_b : chain_b;
    end

    assign a_if.so = chain_a[NA-1];
    assign b_if.so = chain_b[NB-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Loaded pattern after 'caps' functional clocks of a D=Q or D=~Q chain.
    function automatic logic [31:0] ref_resp(input logic [31:0] pat, input bit inv,
                                             input int caps, input int n);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        r    = pat & mask;
        for (int k = 0; k < caps; k++) begin
            if (inv) r = ~r & mask;
        end
        return r;
    endfunction

    // One test on instance A; call at a negedge. pat_in is scrambled after
    // the start edge, and with poke set start is re-pulsed in LOAD, UNLOAD
    // and the done cycle, all of which must be ignored.
    task automatic run_a(input string tag, input logic [NA-1:0] pat, input bit inv,
                         input bit poke);
        int first_done = 0;
        int n_done     = 0;
        int busy_at_done = 1;
        int lim        = 2 * NA + CA + 6;
        inv_a        = inv;
        a_if.pat_in  = pat;
        a_if.start   = 1'b1;
        @(posedge clk);
        #1;
        a_if.start  = 1'b0;
        a_if.pat_in = ~pat;
        for (int cyc = 1; cyc <= lim; cyc++) begin
            if (a_if.done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done   = cyc;
                    busy_at_done = int'(a_if.busy);
                end
            end
            if (poke) a_if.start = (cyc == 3) || (cyc == NA + CA + 3) || a_if.done;
            @(posedge clk);
            #1;
        end
        a_if.start = 1'b0;
        chk({tag, "_latency"}, first_done, 2 * NA + CA + 1);
        chk({tag, "_done_count"}, n_done, 1);
        chk({tag, "_busy_at_done"}, busy_at_done, 0);
        chk({tag, "_resp"}, a_if.resp_out, ref_resp(pat, inv, CA, NA));
        chk({tag, "_busy_end"}, a_if.busy, 0);
        $display("txn %s pat=%02h inv=%0d poke=%0d resp=%02h done_at=%0d",
                 tag, pat, inv, poke, a_if.resp_out, first_done);
        @(negedge clk);
    endtask

    initial begin
        logic [NA-1:0] pat;
        logic [NB-1:0] pb;
        bit            inv;
        int            n_done;
        int            first_done;
        logic          exp_se;

        a_if.start = 1'b0; a_if.pat_in = '0;
        b_if.start = 1'b0; b_if.pat_in = '0;

        // Reset state
        #2 rn = 1'b0;
        #1;
        chk("rst_se", a_if.se, 0);
        chk("rst_si", a_if.si, 0);
        chk("rst_busy", a_if.busy, 0);
        chk("rst_done", a_if.done, 0);
        chk("rst_resp", a_if.resp_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rn = 1'b1;
        @(negedge clk);

        // Inverting chain, 0xA5 -> 0x5A, done 18 cycles after start
        run_a("inv_a5", 8'hA5, 1'b1, 1'b0);

        // Abort during LOAD cycle 5
        inv_a       = 1'b1;
        a_if.pat_in = 8'h3C;
        a_if.start  = 1'b1;
        @(posedge clk);
        #1;
        a_if.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("abort_se_before", a_if.se, 1);
        #2 rn = 1'b0;
        #1;
        chk("abort_se", a_if.se, 0);
        chk("abort_busy", a_if.busy, 0);
        chk("abort_resp", a_if.resp_out, 0);
        chk("abort_si", a_if.si, 0);
        n_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (a_if.done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        // Release reset and request in the same half-cycle: the first edge
        // with RN high must accept it.
        @(negedge clk);
        rn = 1'b1;
        run_a("restart_ff", 8'hFF, 1'b1, 1'b0);

        // Transparent chain, bit order check
        run_a("hold_01", 8'h01, 1'b0, 1'b0);
        run_a("hold_80", 8'h80, 1'b0, 1'b0);

        // start ignored outside IDLE
        run_a("poke", 8'($urandom), 1'b1, 1'b1);

        // Random patterns and chain behaviours
        for (int t = 0; t < 6; t++) begin
            pat = 8'($urandom);
            inv = 1'($urandom_range(0, 1));
            run_a($sformatf("rand%0d", t), pat, inv, 1'($urandom_range(0, 1)));
        end

        // Instance B: se waveform LOAD(2) CAPTURE(3) UNLOAD(2), done at 8
        pb          = 2'($urandom);
        inv_b       = 1'b1;
        b_if.pat_in = pb;
        b_if.start  = 1'b1;
        @(posedge clk);
        #1;
        b_if.start  = 1'b0;
        b_if.pat_in = ~pb;
        first_done  = 0;
        for (int cyc = 1; cyc <= 2 * NB + CB + 4; cyc++) begin
            exp_se = (cyc <= NB) || ((cyc > NB + CB) && (cyc <= 2 * NB + CB));
            chk($sformatf("b_se_c%0d", cyc), b_if.se, exp_se);
            if (b_if.done && first_done == 0) first_done = cyc;
            @(posedge clk);
            #1;
        end
        chk("b_latency", first_done, 2 * NB + CB + 1);
        chk("b_resp", b_if.resp_out, ref_resp(32'(pb), 1'b1, CB, NB));
        $display("txn b pat=%0h resp=%0h done_at=%0d", pb, b_if.resp_out, first_done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
